instruction_encoder: RTL and testbench

//  Inverse of the hart's decode path: accepts decoded RV32I instruction fields (format, opcode, regs,

---
 rtl/instruction_encoder_pkg.sv | 41 ++++
 rtl/instruction_encoder_pack.sv | 80 ++++++++
 rtl/instruction_encoder.sv | 117 +++++++++++
 tb/tb_instruction_encoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes, field positions
// and the immediate range helper used by the encoder (and its decoder twin).
package instruction_encoder_pkg;

    localparam int ISA_XLEN = 32;
    localparam int ISA_ILEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_format_t;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    // True when imm is a sign-extension of its low 'bits' bits.
    function automatic logic imm_fits(input logic [ISA_XLEN-1:0] imm, input int unsigned bits);
        logic [ISA_XLEN-1:0] hi;
        hi = $unsigned($signed(imm) >>> (bits - 32'd1));
        return (hi == {ISA_XLEN{1'b0}}) || (hi == {ISA_XLEN{1'b1}});
    endfunction

endpackage

// File: rtl/instruction_encoder_pack.sv
// Combinational packer: decoded fields + full-width immediate -> instruction
// word, plus a flag when the immediate cannot be represented by the format.
module instruction_encoder_pack
    import instruction_encoder_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic [2:0]      fmt,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    output logic [ILEN-1:0] word,
    output logic            imm_error
);

    // Place each field at its slot; fields a format does not use stay zero.
    always_comb begin
        word      = {ILEN{1'b0}};
        imm_error = 1'b0;
        word[OPCODE_LSB +: 7] = opcode;
        case (fmt)
            FMT_R: begin
                word[RD_LSB +: 5]     = rd;
                word[FUNCT3_LSB +: 3] = funct3;
                word[RS1_LSB +: 5]    = rs1;
                word[RS2_LSB +: 5]    = rs2;
                word[FUNCT7_LSB +: 7] = funct7;
            end
            FMT_I: begin
                word[RD_LSB +: 5]     = rd;
                word[FUNCT3_LSB +: 3] = funct3;
                word[RS1_LSB +: 5]    = rs1;
                word[31:20]           = imm[11:0];
                imm_error             = !imm_fits(imm, 32'd12);
            end
            FMT_S: begin
                word[FUNCT3_LSB +: 3] = funct3;
                word[RS1_LSB +: 5]    = rs1;
                word[RS2_LSB +: 5]    = rs2;
                word[31:25]           = imm[11:5];
                word[11:7]            = imm[4:0];
                imm_error             = !imm_fits(imm, 32'd12);
            end
            FMT_B: begin
                word[FUNCT3_LSB +: 3] = funct3;
                word[RS1_LSB +: 5]    = rs1;
                word[RS2_LSB +: 5]    = rs2;
                word[31]              = imm[12];
                word[30:25]           = imm[10:5];
                word[11:8]            = imm[4:1];
                word[7]               = imm[11];
                imm_error             = !imm_fits(imm, 32'd13) || imm[0];
            end
            FMT_U: begin
                word[RD_LSB +: 5] = rd;
                word[31:12]       = imm[31:12];
                imm_error         = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                word[RD_LSB +: 5] = rd;
                word[31]          = imm[20];
                word[30:21]       = imm[10:1];
                word[20]          = imm[11];
                word[19:12]       = imm[19:12];
                imm_error         = !imm_fits(imm, 32'd21) || imm[0];
            end
            default: begin
                // Unknown format: emit an all-zero word and flag it.
                word      = {ILEN{1'b0}};
                imm_error = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage elastic RV32I encoder: S1 holds the packed word and range flag,
// S2 presents word + byte PC to the consumer. valid/ready on both sides.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_format,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_imm_error,
    output logic            error_sticky
);

    logic [ILEN-1:0] pack_word_s;
    logic            pack_err_s;
    logic            s2_adv_s;
    logic            s1_adv_s;
    logic            out_fire_s;
    logic [XLEN-1:0] pc_inc_s;

    logic            s1_valid_r;
    logic [ILEN-1:0] s1_word_r;
    logic            s1_err_r;
    logic            s2_valid_r;
    logic [ILEN-1:0] s2_word_r;
    logic            s2_err_r;
    logic [XLEN-1:0] s2_pc_r;
    logic [XLEN-1:0] pc_r;
    logic            sticky_r;

    instruction_encoder_pack #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_pack (
        .fmt       (in_format),
        .opcode    (in_opcode),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .imm       (in_imm),
        .word      (pack_word_s),
        .imm_error (pack_err_s)
    );

    assign s2_adv_s   = !s2_valid_r || out_ready;
    assign s1_adv_s   = !s1_valid_r || s2_adv_s;
    assign out_fire_s = s2_valid_r && out_ready;
    assign pc_inc_s   = pc_r + XLEN'(32'd4);
    assign in_ready   = s1_adv_s;

    assign out_valid     = s2_valid_r;
    assign out_instr     = s2_word_r;
    assign out_pc        = s2_pc_r;
    assign out_imm_error = s2_err_r;
    assign error_sticky  = sticky_r;

    // S1: capture the packed word whenever the stage is free to move.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_word_r  <= {ILEN{1'b0}};
            s1_err_r   <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            s1_word_r  <= pack_word_s;
            s1_err_r   <= pack_err_s;
        end
    end

    // S2 + PC + sticky error: pc_r is the address of the word in S2 (or of the
    // next word when S2 is empty), so an entering word that replaces one being
    // accepted this cycle takes the already-incremented address.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_word_r  <= {ILEN{1'b0}};
            s2_err_r   <= 1'b0;
            s2_pc_r    <= BASE_ADDR;
            pc_r       <= BASE_ADDR;
            sticky_r   <= 1'b0;
        end else begin
            if (out_fire_s) begin
                pc_r <= pc_inc_s;
                if (s2_err_r) begin
                    sticky_r <= 1'b1;
                end
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_word_r <= s1_word_r;
                    s2_err_r  <= s1_err_r;
                    s2_pc_r   <= out_fire_s ? pc_inc_s : pc_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: table of known encodings, backpressure and
// reset corner cases, and a random encode -> decode round trip.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_format;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_imm_error;
    logic        error_sticky;

    always #5 clk = ~clk;

    instruction_encoder #(.XLEN(32), .ILEN(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_imm_error(out_imm_error), .error_sticky(error_sticky)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        use_word;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t        sb_q[$];
    vec_t        cur;
    vec_t        tbl[20];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc = 32'd0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_instr, prev_pc;
    logic        prev_err;
    logic        rnd_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] word, input logic err);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.use_word = 1'b1; v.word = word; v.err = err;
        return v;
    endfunction

    // Independent decoder: rebuild fields from the word and compare with the bundle.
    function automatic logic rt_ok(input vec_t v, input logic [31:0] w);
        logic ok;
        ok = (w[6:0] == v.op);
        case (v.fmt)
            FMT_R: ok = ok && (w[11:7] == v.rd) && (w[14:12] == v.f3) && (w[19:15] == v.rs1)
                           && (w[24:20] == v.rs2) && (w[31:25] == v.f7);
            FMT_I: ok = ok && (w[11:7] == v.rd) && (w[14:12] == v.f3) && (w[19:15] == v.rs1)
                           && ({{20{w[31]}}, w[31:20]} == v.imm);
            FMT_S: ok = ok && (w[14:12] == v.f3) && (w[19:15] == v.rs1) && (w[24:20] == v.rs2)
                           && ({{20{w[31]}}, w[31:25], w[11:7]} == v.imm);
            FMT_B: ok = ok && (w[14:12] == v.f3) && (w[19:15] == v.rs1) && (w[24:20] == v.rs2)
                           && ({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} == v.imm);
            FMT_U: ok = ok && (w[11:7] == v.rd) && ({w[31:12], 12'h000} == v.imm);
            FMT_J: ok = ok && (w[11:7] == v.rd)
                           && ({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} == v.imm);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        logic [31:0] r;
        r = $urandom;
        v.fmt = 3'($urandom_range(0, 5));
        v.op = 7'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        case (v.fmt)
            FMT_I, FMT_S: v.imm = {{20{r[11]}}, r[11:0]};
            FMT_B:        v.imm = {{19{r[12]}}, r[12:1], 1'b0};
            FMT_J:        v.imm = {{11{r[20]}}, r[20:1], 1'b0};
            FMT_U:        v.imm = {r[31:12], 12'h000};
            default:      v.imm = r;
        endcase
        v.use_word = 1'b0; v.word = 32'd0; v.err = 1'b0;
        return v;
    endfunction

    // Scoreboard: predict input handshakes, check output handshakes and holds.
    always @(negedge clk) begin
        vec_t v;
        if (reset) begin
            sb_q.delete();
            exp_pc = 32'd0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_instr", out_instr, prev_instr);
                chk("hold_pc", out_pc, prev_pc);
                chk("hold_err", {31'd0, out_imm_error}, {31'd0, prev_err});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got %08h expected no word", out_instr);
                end else begin
                    v = sb_q.pop_front();
                    chk("out_pc", out_pc, exp_pc);
                    chk("out_imm_error", {31'd0, out_imm_error}, {31'd0, v.err});
                    if (v.use_word) chk("out_instr", out_instr, v.word);
                    else chk("roundtrip", {31'd0, rt_ok(v, out_instr)}, 32'd1);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_pc    = out_pc;
            prev_err   = out_imm_error;
            if (in_valid && in_ready) sb_q.push_back(cur);
        end
    end

    task automatic drive(input vec_t v);
        cur = v;
        in_format = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
    endtask

    task automatic push(input vec_t v);
        logic taken;
        taken = 1'b0;
        drive(v);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got in_ready=0 expected acceptance");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        tbl[1]  = mk(FMT_S, OPCODE_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
        tbl[2]  = mk(FMT_J, OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
        tbl[3]  = mk(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        tbl[4]  = mk(FMT_U, OPCODE_LUI, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        tbl[5]  = mk(FMT_R, OPCODE_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
        tbl[6]  = mk(FMT_R, OPCODE_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0);
        tbl[7]  = mk(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd5, 3'd0, 7'h7F, 32'd5, 32'h0050_0093, 1'b0);
        tbl[8]  = mk(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        tbl[9]  = mk(FMT_B, OPCODE_BRANCH, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
        tbl[10] = mk(FMT_J, OPCODE_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
        tbl[11] = mk(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF0_0093, 1'b0);
        tbl[12] = mk(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1);
        tbl[13] = mk(FMT_J, OPCODE_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0020_006F, 1'b1);
        tbl[14] = mk(3'd7, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0000_0000, 1'b1);
        tbl[15] = mk(FMT_U, OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
        tbl[16] = mk(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h8000_0063, 1'b1);
        tbl[17] = mk(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0000_0063, 1'b1);
        tbl[18] = mk(FMT_J, OPCODE_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_006F, 1'b1);
        tbl[19] = mk(FMT_S, OPCODE_STORE, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'hFFFF_F7FF, 32'h7E00_2FA3, 1'b1);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_done = 1'b0;
        in_format = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_imm_error}, 32'd0);
        chk("rst_sticky", {31'd0, error_sticky}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Legal encodings back-to-back, then the out-of-range ones.
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 12; i++) push(tbl[i]);
        drain();
        chk("sticky_clean", {31'd0, error_sticky}, 32'd0);
        for (int i = 12; i < 20; i++) push(tbl[i]);
        drain();
        chk("sticky_set", {31'd0, error_sticky}, 32'd1);

        // Backpressure: two words fill the pipe, third waits; then release.
        pulse_reset();
        @(negedge clk);
        chk("sticky_cleared", {31'd0, error_sticky}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        push(tbl[0]);
        push(tbl[1]);
        drive(tbl[2]);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_instr", out_instr, 32'h0050_0093);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        push(tbl[2]);
        drain();

        // Reset with both stages full and the consumer ready.
        @(posedge clk);
        #1 out_ready = 1'b0;
        push(tbl[3]);
        push(tbl[4]);
        out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_out_pc", out_pc, 32'd0);
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rstmid_no_ghost", {31'd0, out_valid}, 32'd0);
        push(tbl[5]);
        drain();

        // Random round trip with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 300; i++) push(rand_vec());
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
